// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: the legacy define set
// (widths, enable levels, IF state encodings) plus the typed view of them
// used by the RTL.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define RstEnable      1'b1
`define ChipEnable     1'b1
`define InstAddrWidth  32
`define InstDataWidth  32
`define ZeroWord       32'h0000_0000
`define IfIdle         2'b00
`define IfRun          2'b01
`define IfHold         2'b10
`define IfDone         2'b11
`endif

package inst_fetch_pkg;

    localparam int ADDR_W = `InstAddrWidth;
    localparam int DATA_W = `InstDataWidth;

    localparam logic RST_ENABLE  = `RstEnable;
    localparam logic CHIP_ENABLE = `ChipEnable;
    localparam logic [DATA_W-1:0] ZERO_WORD = `ZeroWord;

    typedef enum logic [1:0] {
        IF_IDLE = `IfIdle,
        IF_RUN  = `IfRun,
        IF_HOLD = `IfHold,
        IF_DONE = `IfDone
    } if_state_e;

    // Per-edge decision taken by the priority mux and consumed by pc_reg.
    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_STALL  = 3'd2,
        ACT_BRANCH = 3'd3,
        ACT_SEQ    = 3'd4
    } fetch_act_e;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// PC register and fetch sequencer: owns pc, the registered rom_ce/halted
// outputs, the pending redirect captured during a stall, and the IF state.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IF_IDLE | one cycle after reset release, ROM disabled, nothing fetched
// IF_RUN  | fetching sequentially, redirects applied immediately
// IF_HOLD | stalled; a redirect seen meanwhile is parked in pend_*
// IF_DONE | pc left the populated ROM range; only flush or reset leaves
module inst_fetch_pc_reg import inst_fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] StartAddr  = 32'h0000_0000,
    parameter int unsigned       InstMemNum = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  fetch_act_e        act,
    input  logic [ADDR_W-1:0] tgt,
    input  logic              pend_set,
    output logic [ADDR_W-1:0] pc,
    output logic              rom_ce,
    output logic              halted,
    output if_state_e         state,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_target
);

    // First byte address past the populated ROM, one bit wider so it cannot wrap.
    localparam logic [ADDR_W:0] PC_LIMIT = {InstMemNum[ADDR_W-2:0], 2'b00};

    if_state_e         next_state;
    logic [ADDR_W-1:0] next_pc;
    logic              next_pend_valid;
    logic [ADDR_W-1:0] next_pend_target;
    logic              next_out_of_range;

    assign next_out_of_range = ({1'b0, next_pc} >= PC_LIMIT);

    // Next pc, pending redirect and state from the action chosen this cycle.
    always_comb begin
        next_state       = state;
        next_pc          = pc;
        next_pend_valid  = pend_valid;
        next_pend_target = pend_target;

        case (act)
            ACT_FLUSH, ACT_BRANCH: begin
                next_pc         = tgt;
                next_pend_valid = 1'b0;
            end
            ACT_SEQ: begin
                next_pc         = pc + ADDR_W'(4);
                next_pend_valid = 1'b0;
            end
            ACT_STALL: begin
                if (pend_set) begin
                    next_pend_valid  = 1'b1;
                    next_pend_target = tgt;
                end
            end
            default: ;
        endcase

        if (state == IF_IDLE) begin
            next_state = IF_RUN;
        end else begin
            case (act)
                ACT_STALL:                   next_state = IF_HOLD;
                ACT_FLUSH, ACT_BRANCH, ACT_SEQ:
                    next_state = next_out_of_range ? IF_DONE : IF_RUN;
                default:                     next_state = state;
            endcase
        end
    end

    // State, pc and pending redirect registers; rom_ce/halted follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state       <= IF_IDLE;
            pc          <= StartAddr;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            rom_ce      <= ~CHIP_ENABLE;
            halted      <= 1'b0;
        end else begin
            state       <= next_state;
            pc          <= next_pc;
            pend_valid  <= next_pend_valid;
            pend_target <= next_pend_target;
            rom_ce      <= ((next_state == IF_RUN) || (next_state == IF_HOLD))
                           ? CHIP_ENABLE : ~CHIP_ENABLE;
            halted      <= (next_state == IF_DONE);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the combinational instruction ROM, picks
// the per-edge action (flush > stall > branch > pending redirect > sequential)
// and holds the IF/ID pipeline register.
// Optional build macro INST_FETCH_ALIGN_CHK_EN: misaligned redirect targets
// are rejected and flagged on the sticky misalign_err output; without it the
// low two target bits are simply cleared.
module inst_fetch import inst_fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] StartAddr  = 32'h0000_0000,
    parameter int unsigned       InstMemNum = 32,
    parameter bit                DelaySlot  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid,
    output logic              halted
`ifdef INST_FETCH_ALIGN_CHK_EN
    ,
    output logic              misalign_err
`endif
);

    if_state_e         state;
    logic [ADDR_W-1:0] pc;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    fetch_act_e        act;
    logic [ADDR_W-1:0] act_tgt;
    logic              pend_set;

    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] flush_tgt;
    logic              branch_req;
    logic              flush_req;

`ifdef INST_FETCH_ALIGN_CHK_EN
    // A misaligned target drops the request entirely, so sequential fetch carries on.
    assign branch_tgt = branch_target;
    assign flush_tgt  = flush_target;
    assign branch_req = branch_flag && (branch_target[1:0] == 2'b00);
    assign flush_req  = flush && (flush_target[1:0] == 2'b00);
`else
    assign branch_tgt = word_align(branch_target);
    assign flush_tgt  = word_align(flush_target);
    assign branch_req = branch_flag;
    assign flush_req  = flush;
`endif

    assign rom_addr = pc;

    // Priority mux: one action per edge, plus the target pc_reg should use.
    always_comb begin
        act      = ACT_NONE;
        act_tgt  = branch_tgt;
        pend_set = 1'b0;

        if (state == IF_IDLE) begin
            act = ACT_NONE;
        end else if (flush_req) begin
            act     = ACT_FLUSH;
            act_tgt = flush_tgt;
        end else if (state == IF_DONE) begin
            act = ACT_NONE;
        end else if (stall) begin
            act      = ACT_STALL;
            act_tgt  = branch_tgt;
            pend_set = branch_req;
        end else if (branch_req) begin
            act     = ACT_BRANCH;
            act_tgt = branch_tgt;
        end else if ((state == IF_HOLD) && pend_valid) begin
            act     = ACT_BRANCH;
            act_tgt = pend_target;
        end else begin
            act = ACT_SEQ;
        end
    end

    inst_fetch_pc_reg #(
        .StartAddr  (StartAddr),
        .InstMemNum (InstMemNum)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .act         (act),
        .tgt         (act_tgt),
        .pend_set    (pend_set),
        .pc          (pc),
        .rom_ce      (rom_ce),
        .halted      (halted),
        .state       (state),
        .pend_valid  (pend_valid),
        .pend_target (pend_target)
    );

    // IF/ID pipeline register; a squashed or flushed slot becomes a NOP bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            id_pc    <= ZERO_WORD;
            id_inst  <= ZERO_WORD;
            id_valid <= 1'b0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    id_inst  <= ZERO_WORD;
                    id_valid <= 1'b0;
                end
                ACT_BRANCH: begin
                    if (DelaySlot) begin
                        id_pc    <= pc;
                        id_inst  <= rom_inst;
                        id_valid <= 1'b1;
                    end else begin
                        id_inst  <= ZERO_WORD;
                        id_valid <= 1'b0;
                    end
                end
                ACT_SEQ: begin
                    id_pc    <= pc;
                    id_inst  <= rom_inst;
                    id_valid <= 1'b1;
                end
                ACT_NONE: begin
                    // The last in-range word lives one cycle into DONE, then goes invalid.
                    if (state == IF_DONE) begin
                        id_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INST_FETCH_ALIGN_CHK_EN
    // Sticky flag for any rejected redirect while fetching; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            misalign_err <= 1'b0;
        end else if (state != IF_IDLE) begin
            if ((flush && (flush_target[1:0] != 2'b00)) ||
                (branch_flag && (state != IF_DONE) && (branch_target[1:0] != 2'b00))) begin
                misalign_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator that drives the instruction ROM interface (ce/addr in, inst out) and registers the result into the IF/ID pipeline register.
- Owns the PC and applies stall, branch redirect and exception flush.
- Stops fetching when the PC leaves the populated ROM range.
- The ROM is combinational: the inst for rom_addr is valid in the same cycle.

Parameters:
- StartAddr, 32'h0000_0000, PC value after reset.
- InstMemNum, 32, number of ROM words. PC ≥ InstMemNum*4 is out of range.
- DelaySlot, 1, 1 = the instruction fetched in the branch cycle is kept; 0 = it is squashed.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high (`RstEnable).
- rom_ce  out  1  ROM chip enable (`ChipEnable / ~`ChipEnable).
- rom_addr  out  `InstAddrWidth  byte address; always equals pc.
- rom_inst  in  `InstDataWidth  instruction returned by the ROM.
- stall  in  1  hold PC and the IF/ID register.
- branch_flag  in  1  redirect request from ID.
- branch_target  in  `InstAddrWidth  redirect address.
- flush  in  1  exception flush.
- flush_target  in  `InstAddrWidth  exception vector.
- id_pc  out  `InstAddrWidth  PC of the registered instruction.
- id_inst  out  `InstDataWidth  registered instruction (32'h0 = NOP).
- id_valid  out  1  id_inst is valid.
- halted  out  1  fetch stopped because PC is out of range.

Behaviour:
- Reset (async):
  - pc=StartAddr, rom_ce=~`ChipEnable, id_pc=0, id_inst=0, id_valid=0, halted=0.
  - state=IDLE, pending redirect cleared.
  - Reset asserted mid-operation aborts everything immediately.
- States: IDLE, RUN, HOLD, DONE.
- IDLE: rom_ce low for exactly one cycle after reset release, then RUN with rom_ce high. No fetch is registered in IDLE.
- RUN, per edge, in priority order:
  - flush:
    - pc<=flush_target.
    - id_inst<=0, id_valid<=0.
    - Any pending redirect is cleared.
    - Flush also overrides stall and works from HOLD and DONE; from DONE it returns to RUN and clears halted.
  - stall: pc and id_* hold. A concurrent branch_flag is latched into a pending register (target + flag); next state is HOLD.
  - branch_flag:
    - DelaySlot=1: id_* <= {pc, rom_inst, 1}.
    - DelaySlot=0: id_valid<=0 and id_inst<=0.
    - In both cases pc<=branch_target.
  - Otherwise: id_pc<=pc, id_inst<=rom_inst, id_valid<=1, pc<=pc+4 (wraps mod 2^32).
- HOLD:
  - Same hold rules as a RUN stall. A new branch_flag overwrites the pending one (latest wins).
  - On stall deassertion, a pending redirect is applied exactly like a RUN branch_flag in that cycle, then cleared. A live branch_flag in the same cycle takes precedence over the pending one.
  - Returns to RUN.
- DONE:
  - Entered when next pc ≥ InstMemNum*4.
  - rom_ce=~`ChipEnable, halted=1.
  - The last in-range instruction stays registered for one cycle, then id_valid<=0.
  - Only flush or reset exits DONE.
- rom_addr=pc combinationally. rom_ce is a registered output.

Optional Feature:
- Macro: INST_FETCH_ALIGN_CHK_EN.
- Defined:
  - A branch_target or flush_target with [1:0]≠0 is rejected: pc is unchanged, the sequential fetch continues.
  - Sticky output misalign_err (1 bit, reset 0) is set and cleared only by rst.
- Undefined: target bits [1:0] are forced to 2'b00; the misalign_err port does not exist.

Decomposition:
- Shared define file (existing define.v):
  - `InstAddrWidth, `InstDataWidth, `RstEnable, `ChipEnable.
  - Add `ZeroWord.
  - Add state encodings `IfIdle / `IfRun / `IfHold / `IfDone (2 bits).
- One natural sub-module: pc_reg (pc, rom_ce, pending redirect, state).
- inst_fetch itself holds the IF/ID register and the priority mux.

Test Plan:
- ROM loaded with 0x00000001..0x00000010, no stall → after 1 idle cycle id_inst = 1, 2, 3… on successive edges; id_pc = 0, 4, 8…; id_valid=1.
- stall held 3 cycles at pc=8 with branch_flag=1, target=0x20 on cycle 2 → id_* frozen; on release pc=0x20, the delay-slot word at 8 is registered, the next word comes from 0x20.
- DelaySlot=0, branch to 0x10 from pc=4 → one bubble (id_valid=0, id_inst=0), then id_inst=ROM[4].
- flush=1, flush_target=0x0C together with stall=1 and branch_flag=1 → id_valid=0, pc=0x0C; the pending redirect is discarded.
- InstMemNum=4 → after id_pc=0x0C: halted=1, rom_ce low, id_valid=0; a subsequent flush to 0 restarts fetch.
- rst asserted mid-stream at an arbitrary phase → all outputs reach their reset values without a clock edge; fetch restarts at StartAddr after 1 idle cycle.
